conf_regs_bank: RTL and testbench

- Parametrised successor of the scope configuration register block.
- Holds NUM_REGS generic DATA_WIDTH registers loaded over the Simple Interface (SI), with readback, error reporting and a command register (start/abort/restore-defaults).
- Double-buffered: SI writes land in a shadow bank; the active bank driving analog front-end, DAC, trigger and decimation logic only updates while acquisition is idle.
- Sits between the SI decoder and the acquisition/trigger/DAC blocks.

---
 rtl/conf_regs_bank.sv | 170 +++++++++++++++++
 tb/tb_conf_regs_bank.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/conf_regs_bank.sv
// Double-buffered configuration register bank behind the Simple Interface.
// Writes go to the shadow bank; the active bank follows only while acquisition is idle.
module conf_regs_bank #(
    parameter int                              DATA_WIDTH = 16,
    parameter int                              ADDR_WIDTH = 8,
    parameter int                              NUM_REGS   = 8,
    parameter logic [ADDR_WIDTH-1:0]           ADDR_CMD   = 8'hF0,
    parameter logic [NUM_REGS*DATA_WIDTH-1:0]  DEFAULTS   = '0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [ADDR_WIDTH-1:0]          si_addr,
    input  logic [DATA_WIDTH-1:0]          si_data,
    input  logic                           si_rd,
    input  logic                           si_rdy,
    output logic                           si_ack,
    output logic                           si_err,
    output logic [DATA_WIDTH-1:0]          rd_data,
    input  logic                           busy,
    output logic [NUM_REGS*DATA_WIDTH-1:0] regs_active,
    output logic [NUM_REGS-1:0]            reg_changed,
    output logic                           pending,
    output logic                           start,
    output logic                           abort
);

    function automatic logic [DATA_WIDTH-1:0] def_val(input int idx);
        return DEFAULTS[idx*DATA_WIDTH +: DATA_WIDTH];
    endfunction

    logic [DATA_WIDTH-1:0] shadow_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] shadow_d [NUM_REGS];
    logic [DATA_WIDTH-1:0] active_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] active_d [NUM_REGS];
    logic [NUM_REGS-1:0]   pend_q, pend_d;
    logic [NUM_REGS-1:0]   changed_q, changed_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                  ack_q, ack_d;
    logic                  err_q, err_d;
    logic                  start_q, start_d;
    logic                  abort_q, abort_d;

    logic [NUM_REGS-1:0]   hit;
    logic                  is_data;
    logic                  is_cmd;
    logic                  pend_any;

    always_comb begin
        hit = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (si_addr == ADDR_WIDTH'(i)) hit[i] = 1'b1;
        end
    end

    assign is_data  = |hit;
    assign is_cmd   = (si_addr == ADDR_CMD);
    assign pend_any = |pend_q;

    always_comb begin
        shadow_d  = shadow_q;
        active_d  = active_q;
        pend_d    = pend_q;
        changed_d = '0;
        rd_data_d = '0;
        ack_d     = 1'b0;
        err_d     = 1'b0;
        start_d   = 1'b0;
        abort_d   = 1'b0;

        // Deferred updates are applied first so a same-edge write overrides them.
        if (!busy) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (pend_q[i]) begin
                    active_d[i]  = shadow_q[i];
                    changed_d[i] = 1'b1;
                    pend_d[i]    = 1'b0;
                end
            end
        end

        if (si_rdy) begin
            ack_d = 1'b1;
            if (si_rd) begin
                if (is_data) begin
                    for (int i = 0; i < NUM_REGS; i++) begin
                        if (hit[i]) rd_data_d = shadow_q[i];
                    end
                end else if (is_cmd) begin
                    rd_data_d = DATA_WIDTH'({pend_any, busy});
                end else begin
                    err_d = 1'b1;
                end
            end else if (is_data) begin
                for (int i = 0; i < NUM_REGS; i++) begin
                    if (hit[i]) begin
                        shadow_d[i] = si_data;
                        if (!busy) begin
                            active_d[i]  = si_data;
                            changed_d[i] = 1'b1;
                        end else begin
                            pend_d[i] = 1'b1;
                        end
                    end
                end
            end else if (is_cmd) begin
                // Command bits take effect in the order restore, abort, start.
                if (si_data[2]) begin
                    for (int i = 0; i < NUM_REGS; i++) begin
                        shadow_d[i] = def_val(i);
                        if (!busy) active_d[i] = def_val(i);
                    end
                    if (!busy) begin
                        changed_d = '1;
                        pend_d    = '0;
                    end else begin
                        pend_d = '1;
                    end
                end
                if (si_data[1]) abort_d = 1'b1;
                if (si_data[0]) begin
                    if (!busy && !pend_any) start_d = 1'b1;
                    else                    err_d   = 1'b1;
                end
            end else begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                shadow_q[i] <= def_val(i);
                active_q[i] <= def_val(i);
            end
            pend_q    <= '0;
            changed_q <= '0;
            rd_data_q <= '0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            start_q   <= 1'b0;
            abort_q   <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                shadow_q[i] <= shadow_d[i];
                active_q[i] <= active_d[i];
            end
            pend_q    <= pend_d;
            changed_q <= changed_d;
            rd_data_q <= rd_data_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
            start_q   <= start_d;
            abort_q   <= abort_d;
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign regs_active[g*DATA_WIDTH +: DATA_WIDTH] = active_q[g];
    end

    assign si_ack      = ack_q;
    assign si_err      = err_q;
    assign rd_data     = rd_data_q;
    assign reg_changed = changed_q;
    assign pending     = |pend_q;
    assign start       = start_q;
    assign abort       = abort_q;

endmodule

// File: tb/tb_conf_regs_bank.sv
// Scoreboard bench for conf_regs_bank: each transaction queues its expected
// response word {ack, err, rd_data, reg_changed, start, abort}.
module tb_conf_regs_bank;

    localparam int DW = 16;
    localparam int AW = 8;
    localparam int NR = 8;
    localparam logic [AW-1:0]    CMD = 8'hF0;
    localparam logic [NR*DW-1:0] DEF = 128'h0000_0000_0000_0000_0000_0000_8080_0000;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [AW-1:0] si_addr = '0;
    logic [DW-1:0] si_data = '0;
    logic          si_rd = 1'b0;
    logic          si_rdy = 1'b0;
    logic          si_ack, si_err;
    logic [DW-1:0] rd_data;
    logic          busy = 1'b0;
    logic [NR*DW-1:0] regs_active;
    logic [NR-1:0] reg_changed;
    logic          pending, start, abort;

    conf_regs_bank #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REGS(NR), .ADDR_CMD(CMD), .DEFAULTS(DEF)
    ) dut (
        .clk(clk), .rst(rst), .si_addr(si_addr), .si_data(si_data), .si_rd(si_rd),
        .si_rdy(si_rdy), .si_ack(si_ack), .si_err(si_err), .rd_data(rd_data),
        .busy(busy), .regs_active(regs_active), .reg_changed(reg_changed),
        .pending(pending), .start(start), .abort(abort)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [27:0] resp;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp  = 0;
    int          n_fail = 0;
    logic [NR*DW-1:0] exp_active;

    function automatic logic [27:0] rsp(input logic ack, input logic err, input logic [15:0] rd,
                                        input logic [7:0] chg, input logic st, input logic ab);
        return {ack, err, rd, chg, st, ab};
    endfunction

    // Drives one cycle of stimulus, queues its expected response, and returns 1 ns after the edge.
    task automatic step(input string name, input logic rdy, input logic rd, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic [27:0] e);
        exp_t x;
        si_rdy = rdy; si_rd = rd; si_addr = a; si_data = d;
        x.name = name; x.resp = e;
        sb.push_back(x);
        @(posedge clk);
        #1;
        si_rdy = 1'b0;
    endtask

    function automatic logic [27:0] observed();
        return {si_ack, si_err, rd_data, reg_changed, start, abort};
    endfunction

    task automatic test_reset();
        rst = 1'b0; busy = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (regs_active !== DEF) begin
            n_fail++; $display("FAIL reset_active got %h want %h", regs_active, DEF);
        end
        n_cmp++;
        if (observed() !== 28'h0 || pending !== 1'b0) begin
            n_fail++; $display("FAIL reset_strobes got %h/%b want 0/0", observed(), pending);
        end
        rst = 1'b1;
        exp_active = DEF;
    endtask

    task automatic test_write_idle();
        exp_t e;
        busy = 1'b0;
        step("wr3", 1, 0, 8'd3, 16'd1024, rsp(1, 0, 16'd0, 8'h08, 0, 0));
        e = sb.pop_front(); n_cmp++;
        if (observed() !== e.resp) begin n_fail++; $display("FAIL %s got %h want %h", e.name, observed(), e.resp); end
        exp_active[3*DW +: DW] = 16'd1024;
        n_cmp++;
        if (regs_active !== exp_active) begin n_fail++; $display("FAIL wr3_active got %h want %h", regs_active, exp_active); end
        step("rd3", 1, 1, 8'd3, 16'h0, rsp(1, 0, 16'd1024, 8'h00, 0, 0));
        e = sb.pop_front(); n_cmp++;
        if (observed() !== e.resp) begin n_fail++; $display("FAIL %s got %h want %h", e.name, observed(), e.resp); end
        step("idle", 0, 0, 8'd3, 16'h0, rsp(0, 0, 16'd0, 8'h00, 0, 0));
        e = sb.pop_front(); n_cmp++;
        if (observed() !== e.resp) begin n_fail++; $display("FAIL %s got %h want %h", e.name, observed(), e.resp); end
    endtask

    task automatic test_busy_pending();
        exp_t e;
        busy = 1'b1;
        step("bwr2a", 1, 0, 8'd2, 16'h8010, rsp(1, 0, 16'd0, 8'h00, 0, 0));
        step("bwr2b", 1, 0, 8'd2, 16'h7F10, rsp(1, 0, 16'd0, 8'h00, 0, 0));
        step("rdstat", 1, 1, CMD, 16'h0, rsp(1, 0, 16'h0003, 8'h00, 0, 0));
        step("startrej", 1, 0, CMD, 16'h0001, rsp(1, 1, 16'd0, 8'h00, 0, 0));
        while (sb.size() > 0) begin
            e = sb.pop_front(); n_cmp++;
            if (e.name == "bwr2b" || e.name == "bwr2a" || e.name == "rdstat" || e.name == "startrej") begin
                if (e.resp[27] !== 1'b1) begin n_fail++; $display("FAIL %s_queued got ack=0 want ack=1", e.name); end
            end
        end
        n_cmp++;
        if (regs_active !== exp_active || pending !== 1'b1) begin
            n_fail++; $display("FAIL busy_hold got %h/%b want %h/1", regs_active, pending, exp_active);
        end
        busy = 1'b0;
        step("apply", 0, 0, 8'd0, 16'h0, rsp(0, 0, 16'd0, 8'h04, 0, 0));
        e = sb.pop_front(); n_cmp++;
        if (observed() !== e.resp) begin n_fail++; $display("FAIL %s got %h want %h", e.name, observed(), e.resp); end
        exp_active[2*DW +: DW] = 16'h7F10;
        n_cmp++;
        if (regs_active !== exp_active || pending !== 1'b0) begin
            n_fail++; $display("FAIL apply_active got %h/%b want %h/0", regs_active, pending, exp_active);
        end
        step("apply_once", 0, 0, 8'd0, 16'h0, rsp(0, 0, 16'd0, 8'h00, 0, 0));
        e = sb.pop_front(); n_cmp++;
        if (observed() !== e.resp) begin n_fail++; $display("FAIL %s got %h want %h", e.name, observed(), e.resp); end
    endtask

    task automatic test_busy_pending_responses();
        exp_t e;
        busy = 1'b1;
        step("bwr1", 1, 0, 8'd1, 16'h1234, rsp(1, 0, 16'd0, 8'h00, 0, 0));
        e = sb.pop_front(); n_cmp++;
        if (observed() !== e.resp) begin n_fail++; $display("FAIL %s got %h want %h", e.name, observed(), e.resp); end
        step("rdstat_b", 1, 1, CMD, 16'h0, rsp(1, 0, 16'h0003, 8'h00, 0, 0));
        e = sb.pop_front(); n_cmp++;
        if (observed() !== e.resp) begin n_fail++; $display("FAIL %s got %h want %h", e.name, observed(), e.resp); end
        step("startrej_b", 1, 0, CMD, 16'h0001, rsp(1, 1, 16'd0, 8'h00, 0, 0));
        e = sb.pop_front(); n_cmp++;
        if (observed() !== e.resp) begin n_fail++; $display("FAIL %s got %h want %h", e.name, observed(), e.resp); end
        // Busy drops on the same edge as a new write to the pending register.
        busy = 1'b0;
        step("apply_wr1", 1, 0, 8'd1, 16'h4321, rsp(1, 0, 16'd0, 8'h02, 0, 0));
        e = sb.pop_front(); n_cmp++;
        if (observed() !== e.resp) begin n_fail++; $display("FAIL %s got %h want %h", e.name, observed(), e.resp); end
        exp_active[1*DW +: DW] = 16'h4321;
        n_cmp++;
        if (regs_active !== exp_active || pending !== 1'b0) begin
            n_fail++; $display("FAIL apply_wr1_active got %h/%b want %h/0", regs_active, pending, exp_active);
        end
    endtask

    task automatic test_start_abort();
        exp_t e;
        busy = 1'b0;
        step("start", 1, 0, CMD, 16'h0001, rsp(1, 0, 16'd0, 8'h00, 1, 0));
        step("idle2", 0, 0, CMD, 16'h0001, rsp(0, 0, 16'd0, 8'h00, 0, 0));
        e = sb.pop_front(); n_cmp++;
        if (e.resp !== rsp(1, 0, 16'd0, 8'h00, 1, 0)) begin n_fail++; $display("FAIL order got %h want start", e.resp); end
        busy = 1'b1;
        step("abort", 1, 0, CMD, 16'h0002, rsp(1, 0, 16'd0, 8'h00, 0, 1));
        e = sb.pop_back(); n_cmp++;
        if (observed() !== e.resp) begin n_fail++; $display("FAIL %s got %h want %h", e.name, observed(), e.resp); end
        busy = 1'b0;
        step("start2", 1, 0, CMD, 16'h0001, rsp(1, 0, 16'd0, 8'h00, 1, 0));
        e = sb.pop_back(); n_cmp++;
        if (observed() !== e.resp) begin n_fail++; $display("FAIL %s got %h want %h", e.name, observed(), e.resp); end
        step("start_once", 0, 0, CMD, 16'h0, rsp(0, 0, 16'd0, 8'h00, 0, 0));
        e = sb.pop_back(); n_cmp++;
        if (observed() !== e.resp) begin n_fail++; $display("FAIL %s got %h want %h", e.name, observed(), e.resp); end
        sb.delete();
    endtask

    task automatic test_bad_addr();
        exp_t e;
        busy = 1'b0;
        step("wr20", 1, 0, 8'h20, 16'hFFFF, rsp(1, 1, 16'd0, 8'h00, 0, 0));
        e = sb.pop_front(); n_cmp++;
        if (observed() !== e.resp) begin n_fail++; $display("FAIL %s got %h want %h", e.name, observed(), e.resp); end
        step("rd09", 1, 1, 8'h09, 16'h0, rsp(1, 1, 16'd0, 8'h00, 0, 0));
        e = sb.pop_front(); n_cmp++;
        if (observed() !== e.resp) begin n_fail++; $display("FAIL %s got %h want %h", e.name, observed(), e.resp); end
        n_cmp++;
        if (regs_active !== exp_active || pending !== 1'b0) begin
            n_fail++; $display("FAIL bad_addr_banks got %h want %h", regs_active, exp_active);
        end
        busy = 1'b1;
        step("rdstat_busy", 1, 1, CMD, 16'h0, rsp(1, 0, 16'h0001, 8'h00, 0, 0));
        e = sb.pop_front(); n_cmp++;
        if (observed() !== e.resp) begin n_fail++; $display("FAIL %s got %h want %h", e.name, observed(), e.resp); end
        busy = 1'b0;
    endtask

    task automatic test_restore();
        exp_t e;
        busy = 1'b0;
        step("wr0", 1, 0, 8'd0, 16'h1111, rsp(1, 0, 16'd0, 8'h01, 0, 0));
        e = sb.pop_front(); n_cmp++;
        if (observed() !== e.resp) begin n_fail++; $display("FAIL %s got %h want %h", e.name, observed(), e.resp); end
        step("wr5", 1, 0, 8'd5, 16'h5555, rsp(1, 0, 16'd0, 8'h20, 0, 0));
        e = sb.pop_front(); n_cmp++;
        if (observed() !== e.resp) begin n_fail++; $display("FAIL %s got %h want %h", e.name, observed(), e.resp); end
        step("restore", 1, 0, CMD, 16'h0004, rsp(1, 0, 16'd0, 8'hFF, 0, 0));
        e = sb.pop_front(); n_cmp++;
        if (observed() !== e.resp) begin n_fail++; $display("FAIL %s got %h want %h", e.name, observed(), e.resp); end
        exp_active = DEF;
        n_cmp++;
        if (regs_active !== DEF) begin n_fail++; $display("FAIL restore_active got %h want %h", regs_active, DEF); end
        step("rd1_def", 1, 1, 8'd1, 16'h0, rsp(1, 0, 16'h8080, 8'h00, 0, 0));
        e = sb.pop_front(); n_cmp++;
        if (observed() !== e.resp) begin n_fail++; $display("FAIL %s got %h want %h", e.name, observed(), e.resp); end
        // Restore while busy marks every register pending; dropping busy applies defaults.
        busy = 1'b1;
        step("bwr0", 1, 0, 8'd0, 16'hAAAA, rsp(1, 0, 16'd0, 8'h00, 0, 0));
        step("brestore", 1, 0, CMD, 16'h0004, rsp(1, 0, 16'd0, 8'h00, 0, 0));
        e = sb.pop_back(); n_cmp++;
        if (observed() !== e.resp) begin n_fail++; $display("FAIL %s got %h want %h", e.name, observed(), e.resp); end
        sb.delete();
        busy = 1'b0;
        step("restore_apply", 0, 0, 8'd0, 16'h0, rsp(0, 0, 16'd0, 8'hFF, 0, 0));
        e = sb.pop_front(); n_cmp++;
        if (observed() !== e.resp) begin n_fail++; $display("FAIL %s got %h want %h", e.name, observed(), e.resp); end
        n_cmp++;
        if (regs_active !== DEF || pending !== 1'b0) begin
            n_fail++; $display("FAIL restore_apply_active got %h/%b want %h/0", regs_active, pending, DEF);
        end
    endtask

    task automatic test_back_to_back_reset();
        exp_t e;
        busy = 1'b0;
        step("b2b6", 1, 0, 8'd6, 16'h6666, rsp(1, 0, 16'd0, 8'h40, 0, 0));
        e = sb.pop_front(); n_cmp++;
        if (observed() !== e.resp) begin n_fail++; $display("FAIL %s got %h want %h", e.name, observed(), e.resp); end
        si_rdy = 1'b1; si_rd = 1'b0; si_addr = 8'd7; si_data = 16'h7777;
        @(posedge clk);
        #1;
        n_cmp++;
        if (si_ack !== 1'b1 || reg_changed !== 8'h80) begin
            n_fail++; $display("FAIL b2b7 got ack=%b chg=%h want ack=1 chg=80", si_ack, reg_changed);
        end
        #2 rst = 1'b0;
        #1;
        n_cmp++;
        if (observed() !== 28'h0 || regs_active !== DEF || pending !== 1'b0) begin
            n_fail++; $display("FAIL mid_reset got %h/%h/%b want 0/%h/0", observed(), regs_active, pending, DEF);
        end
        si_rdy = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        exp_active = DEF;
        step("post_reset_rd6", 1, 1, 8'd6, 16'h0, rsp(1, 0, 16'h0000, 8'h00, 0, 0));
        e = sb.pop_front(); n_cmp++;
        if (observed() !== e.resp) begin n_fail++; $display("FAIL %s got %h want %h", e.name, observed(), e.resp); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        exp_active = DEF;
        test_reset();
        test_write_idle();
        test_busy_pending();
        test_busy_pending_responses();
        test_start_abort();
        test_bad_addr();
        test_restore();
        test_back_to_back_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
